// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Grant and FSM encodings plus the starvation-counter width helper.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_CPU = 1'b0,
        ARB_EXT = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_EXT  = 2'd2
    } grant_t;

    function automatic int cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: CPU memory stage has priority, EXT port gets a
// forced one-cycle grant after MAX_WAIT contended cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req_i,
    input  logic             cpu_we_i,
    input  logic [WIDTH-1:0] cpu_addr_i,
    input  logic [WIDTH-1:0] cpu_wdata_i,
    output logic [WIDTH-1:0] cpu_rdata_o,
    output logic             cpu_stall_o,
    input  logic             ext_valid_i,
    output logic             ext_ready_o,
    input  logic             ext_we_i,
    input  logic [WIDTH-1:0] ext_addr_i,
    input  logic [WIDTH-1:0] ext_wdata_i,
    output logic             ext_rvalid_o,
    output logic [WIDTH-1:0] ext_rdata_o,
    output logic [WIDTH-1:0] ram_adr_o,
    output logic [WIDTH-1:0] ram_wdata_o,
    output logic             ram_we_o,
    input  logic [WIDTH-1:0] ram_rdata_i
);

    localparam int CW = cnt_width(MAX_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

    arb_state_t       state_q, state_d;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             ext_rvalid_q, ext_rvalid_d;
    logic [WIDTH-1:0] ext_rdata_q, ext_rdata_d;
    grant_t           gnt;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        gnt        = GNT_NONE;
        unique case (state_q)
            ARB_CPU: begin
                if (cpu_req_i) begin
                    gnt = GNT_CPU;
                    if (ext_valid_i) begin
                        if (wait_cnt_q != CNT_MAX) begin
                            wait_cnt_d = wait_cnt_q + CW'(1);
                        end
                        if (wait_cnt_q == CNT_LAST) begin
                            state_d = ARB_EXT;
                        end
                    end
                end else if (ext_valid_i) begin
                    gnt        = GNT_EXT;
                    wait_cnt_d = '0;
                end
            end
            ARB_EXT: begin
                // A withdrawn EXT request leaves the slot to the CPU.
                if (ext_valid_i) begin
                    gnt = GNT_EXT;
                end else if (cpu_req_i) begin
                    gnt = GNT_CPU;
                end
                state_d    = ARB_CPU;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        ram_adr_o   = '0;
        ram_wdata_o = '0;
        ram_we_o    = 1'b0;
        cpu_rdata_o = '0;
        ext_ready_o = 1'b0;
        unique case (gnt)
            GNT_CPU: begin
                ram_adr_o   = cpu_addr_i;
                ram_wdata_o = cpu_wdata_i;
                ram_we_o    = cpu_we_i;
                cpu_rdata_o = ram_rdata_i;
            end
            GNT_EXT: begin
                ram_adr_o   = ext_addr_i;
                ram_wdata_o = ext_wdata_i;
                ram_we_o    = ext_we_i;
                ext_ready_o = 1'b1;
            end
            default: begin
            end
        endcase
        cpu_stall_o = cpu_req_i && (gnt != GNT_CPU);
    end

    always_comb begin
        ext_rvalid_d = (gnt == GNT_EXT) && !ext_we_i;
        ext_rdata_d  = ext_rvalid_d ? ram_rdata_i : ext_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_CPU;
            wait_cnt_q   <= '0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign ext_rvalid_o = ext_rvalid_q;
    assign ext_rdata_o  = ext_rdata_q;

endmodule
